// File: rtl/dispatch_buffer.sv
// Dispatch buffer: circular queue between rename and issue. It tracks destination
// registers in a busy table and reports per-source readiness for the two head entries.

`ifndef NUM_INSTRS_COMPLETED
`define NUM_INSTRS_COMPLETED 2
`endif

package dispatch_buffer_pkg;
    // Payload carried on the rename_out_ifc channel.
    typedef struct packed {
        logic        valid;
        logic        uses_rd;
        logic [5:0]  rd;
        logic        uses_rs1;
        logic [5:0]  rs1;
        logic        uses_rs2;
        logic [5:0]  rs2;
        logic [15:0] tag;
    } rename_out_t;
endpackage

module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = `NUM_INSTRS_COMPLETED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_flush,
    input  logic              ext_stall,
    input  rename_out_t       i_renamed [2],
    input  logic [NUM_WB-1:0] wb_valid,
    input  logic [5:0]        wb_prd [NUM_WB],
    output rename_out_t       o_dispatch [2],
    output logic [1:0]        o_rs1_ready,
    output logic [1:0]        o_rs2_ready,
    output logic              int_stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rename_out_t   mem [DEPTH];
    rename_out_t   head_e [2];
    logic [PW-1:0] head, tail, head_p1, slot1_idx;
    logic [CW-1:0] count, enq_n, deq_n;
    logic          enq_en, deq_en;
    logic [63:0]   busy, busy_next;
    logic [DEPTH-1:0] queued;
    logic [1:0]    hit1, hit2;

    // Two free entries are always kept when enqueue is allowed, so a full pair fits.
    assign int_stall = (count > CW'(DEPTH - 2));
    assign enq_en    = !int_stall && !ext_flush;
    assign deq_en    = !ext_stall && !ext_flush;
    assign enq_n     = enq_en ? CW'(i_renamed[0].valid) + CW'(i_renamed[1].valid) : '0;
    assign deq_n     = !deq_en ? '0 : (count >= CW'(2)) ? CW'(2) : count;
    assign slot1_idx = tail + PW'(i_renamed[0].valid);
    assign head_p1   = head + PW'(1);

    // NOTE: storage has no reset; contents past count are never observed.
    always_ff @(posedge clk) begin
        if (enq_en) begin
            if (i_renamed[0].valid) mem[tail]      <= i_renamed[0];
            if (i_renamed[1].valid) mem[slot1_idx] <= i_renamed[1];
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else if (ext_flush) begin
            head  <= tail;
            count <= '0;
            busy  <= busy_next;
        end else begin
            head  <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count + enq_n - deq_n;
            busy  <= busy_next;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_queued
        logic [PW-1:0] off;
        assign off       = PW'(i) - head;
        assign queued[i] = ({1'b0, off} < count);
    end

    // Clears first, then enqueue sets, so a same-cycle set wins.
    always_comb begin
        // NOTE: default assigned first so no path through the block infers a latch.
        busy_next = busy;
        for (int j = 0; j < NUM_WB; j++)
            if (wb_valid[j]) busy_next[wb_prd[j]] = 1'b0;
        if (ext_flush)
            for (int i = 0; i < DEPTH; i++)
                if (queued[i] && mem[i].uses_rd) busy_next[mem[i].rd] = 1'b0;
        if (enq_en)
            for (int k = 0; k < 2; k++)
                if (i_renamed[k].valid && i_renamed[k].uses_rd) busy_next[i_renamed[k].rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign head_e[0] = mem[head];
    assign head_e[1] = mem[head_p1];

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < NUM_WB; j++) begin
                if (wb_valid[j] && wb_prd[j] == head_e[k].rs1) hit1[k] = 1'b1;
                if (wb_valid[j] && wb_prd[j] == head_e[k].rs2) hit2[k] = 1'b1;
            end
    end

    always_comb begin
        o_rs1_ready = '0;
        o_rs2_ready = '0;
        for (int k = 0; k < 2; k++) begin
            o_dispatch[k]       = head_e[k];
            o_dispatch[k].valid = (count > CW'(k));
            o_rs1_ready[k] = o_dispatch[k].valid &&
                (!head_e[k].uses_rs1 || !busy[head_e[k].rs1] || hit1[k]);
            o_rs2_ready[k] = o_dispatch[k].valid &&
                (!head_e[k].uses_rs2 || !busy[head_e[k].rs2] || hit2[k]);
        end
    end

endmodule
